// File: rtl/tone_synth.sv
// tone_synth: note-number driven tone generator for the DE1-SoC audio path.
// A sequential decoder turns note_num into a phase-accumulator tuning word.
// Every CLK_DIV clocks a sample (square/saw/triangle) is produced, attenuated
// and offered on audio_valid/audio_ready.
// Optional build macro: TONE_CLICKFREE_EN (new pitch committed only at a phase wrap).
//
// Handshake: audio_valid means audio_out holds a sample the controller has not
// taken yet; a transfer occurs in any cycle with audio_valid && audio_ready.
// A new sample always replaces the held one on a tick; replacing an unaccepted
// sample counts as an overrun.
module tone_synth #(
  parameter int SAMPLE_W = 32,
  parameter int AMP_LOG2 = 23,
  parameter int PHASE_W  = 24,
  parameter int CLK_DIV  = 1042
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [6:0]                 note_num,
  input  logic [1:0]                 wave_sel,
  input  logic [2:0]                 atten,
  input  logic                       audio_ready,
  output logic signed [SAMPLE_W-1:0] audio_out,
  output logic                       audio_valid,
  output logic                       busy,
  output logic [7:0]                 overrun_cnt,
  output logic [1:0]                 dbg_state
);

  localparam int RAW_W = AMP_LOG2 + 2;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  // Room for a base word shifted up by as many as 10 octaves.
  localparam int TW_W  = PHASE_W + 11;

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_LOAD   = 2'd2;

  // Tuning word of semitone s in the lowest octave (A0 = 27.5 Hz).
  function automatic logic [TW_W-1:0] base_word(input int s);
    real f;
    f = 27.5;
    for (int i = 0; i < s; i++) f = f * 1.0594630943592953;
    for (int i = 0; i < PHASE_W; i++) f = f * 2.0;
    f = f * real'(CLK_DIV) / 50.0e6;
    return TW_W'($rtoi(f + 0.5));
  endfunction

  function automatic logic [11:0][TW_W-1:0] base_table();
    logic [11:0][TW_W-1:0] t;
    for (int s = 0; s < 12; s++) t[s] = base_word(s);
    return t;
  endfunction

  localparam logic [11:0][TW_W-1:0] BASE = base_table();
  localparam logic [TW_W-1:0]       NYQ  = TW_W'(1) << (PHASE_W - 1);
  localparam logic [RAW_W-1:0]      AMP  = RAW_W'(1) << AMP_LOG2;

  logic [DIV_W-1:0]   div;
  logic               tick;
  logic [1:0]         state;
  logic [6:0]         latched;
  logic [6:0]         semi;
  logic [3:0]         oct;
  logic [PHASE_W-1:0] tw;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W:0]   sum;
  logic [TW_W-1:0]    load_word;
  logic               silent;
  logic [AMP_LOG2:0]  p;
  logic [AMP_LOG2-1:0] tri_t;
  logic signed [RAW_W-1:0]    raw;
  logic signed [SAMPLE_W-1:0] ext;
  logic signed [SAMPLE_W-1:0] sample_next;
`ifdef TONE_CLICKFREE_EN
  logic               pending;
  logic [PHASE_W-1:0] pend_tw;
`endif

  assign tick      = (div == DIV_W'(CLK_DIV - 1));
  assign sum       = {1'b0, phase} + {1'b0, tw};
  assign dbg_state = state;
`ifdef TONE_CLICKFREE_EN
  assign busy      = (state != S_RUN) || pending;
`else
  assign busy      = (state != S_RUN);
`endif

  // Sample-rate divider: counts 0..CLK_DIV-1, tick on the last count.
  always_ff @(posedge CLOCK_50) begin
    if (reset)     div <= '0;
    else if (tick) div <= '0;
    else           div <= div + DIV_W'(1);
  end

  // Tuning word for the decoded semitone/octave; rest and above-Nyquist give 0.
  always_comb begin
    load_word = '0;
    if (latched != 7'd0 && semi < 7'd12) begin
      load_word = BASE[semi[3:0]] << oct;
      if (load_word >= NYQ) load_word = '0;
    end
  end

  // Note decoder: divide (note-1) by 12 by repeated subtraction, then load.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state   <= S_RUN;
      latched <= '0;
      semi    <= '0;
      oct     <= '0;
      tw      <= '0;
`ifdef TONE_CLICKFREE_EN
      pending <= 1'b0;
      pend_tw <= '0;
`endif
    end else begin
`ifdef TONE_CLICKFREE_EN
      // Swap pitch only where the waveform restarts, so no discontinuity.
      if (tick && pending && (sum[PHASE_W] || tw == '0)) begin
        tw      <= pend_tw;
        pending <= 1'b0;
      end
`endif
      case (state)
        S_RUN: begin
`ifdef TONE_CLICKFREE_EN
          if (note_num != latched && !pending) begin
`else
          if (note_num != latched) begin
`endif
            latched <= note_num;
            semi    <= note_num - 7'd1;
            oct     <= '0;
            state   <= (note_num == 7'd0) ? S_LOAD : S_DECODE;
          end
        end
        S_DECODE: begin
          if (semi >= 7'd12) begin
            semi <= semi - 7'd12;
            oct  <= oct + 4'd1;
          end else begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
`ifdef TONE_CLICKFREE_EN
          pend_tw <= load_word[PHASE_W-1:0];
          pending <= 1'b1;
`else
          tw      <= load_word[PHASE_W-1:0];
`endif
          state   <= S_RUN;
        end
        default: state <= S_RUN;
      endcase
    end
  end

  // Phase accumulator: advance on each tick, parked at 0 when silent.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      phase <= '0;
    end else if (tick) begin
      if (tw == '0 || !enable) phase <= '0;
      else                     phase <= sum[PHASE_W-1:0];
    end
  end

  // Waveform shaping from the pre-add phase, then sign-extend and attenuate.
  always_comb begin
    p      = phase[PHASE_W-1 -: AMP_LOG2+1];
    tri_t  = p[AMP_LOG2] ? ~p[AMP_LOG2-1:0] : p[AMP_LOG2-1:0];
    silent = (wave_sel == 2'd3) || !enable || (tw == '0);
    raw    = '0;
    case (wave_sel)
      2'd0:    raw = p[AMP_LOG2] ? ~AMP : AMP;
      2'd1:    raw = {1'b0, p} - AMP;
      2'd2:    raw = {1'b0, tri_t, p[AMP_LOG2]} - AMP;
      default: raw = '0;
    endcase
    if (silent) raw = '0;
    ext         = SAMPLE_W'(raw);
    sample_next = ext >>> atten;
  end

  // Output register with valid/ready handshake and saturating overrun count.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      audio_out   <= '0;
      audio_valid <= 1'b0;
      overrun_cnt <= '0;
    end else if (tick) begin
      audio_out   <= sample_next;
      audio_valid <= 1'b1;
      if (audio_valid && !audio_ready && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;
    end else if (audio_valid && audio_ready) begin
      audio_valid <= 1'b0;
    end
  end

endmodule
